// File: rtl/cheri_tbre_sweep.sv
// Background revocation sweep: loads each 8-byte capability slot in a range,
// waits for the revocation verdict and writes revoked caps back untagged.

package cheri_tbre_sweep_pkg;
  typedef struct packed {
    logic       valid;
    logic [4:0] exp;
    logic [8:0] top;
    logic [8:0] base;
    logic [5:0] cperms;
  } reg_cap_t;

  localparam reg_cap_t NULL_REG_CAP = '0;
endpackage

module cheri_tbre_sweep
  import cheri_tbre_sweep_pkg::*;
#(
  parameter int unsigned LdStTimeout = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tbre_start_i,
  input  logic        tbre_stop_i,
  input  logic [31:0] tbre_start_addr_i,
  input  logic [31:0] tbre_end_addr_i,
  output logic        tbre_busy_o,
  output logic        tbre_done_o,
  output logic        tbre_err_o,
  output logic [31:0] tbre_clr_cnt_o,
  output logic        tbre_lsu_req_o,
  output logic        tbre_lsu_we_o,
  output logic        tbre_lsu_is_cap_o,
  output logic [31:0] tbre_lsu_addr_o,
  output logic [31:0] tbre_lsu_wdata_o,
  output reg_cap_t    tbre_lsu_wcap_o,
  input  logic        lsu_tbre_req_done_i,
  input  logic        lsu_tbre_resp_valid_i,
  input  logic        lsu_tbre_resp_err_i,
  input  logic [31:0] rf_wdata_lsu_i,
  input  reg_cap_t    rf_wcap_lsu_i,
  input  logic        tbre_trvk_en_i,
  input  logic        tbre_trvk_clrtag_i,
  input  logic        snoop_lsu_req_done_i,
  input  logic        snoop_lsu_we_i,
  input  logic [31:0] snoop_lsu_addr_i
);

  localparam int unsigned AddrW = 32;
  localparam int unsigned CntW  = 32;
  localparam int unsigned TmoW  = 16;
  localparam logic [AddrW-1:0] SlotMask = AddrW'(32'hFFFF_FFF8);

  typedef enum logic [2:0] {
    IDLE, LD_REQ, LD_WAIT, VK_WAIT, ST_REQ, ST_WAIT, NEXT, FIN
  } state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] cur_addr_q, end_q;
  logic [TmoW-1:0]  tmo_cnt_q;
  logic             conflict_q, stop_pend_q;
  logic [AddrW-1:0] hold_data_q;
  reg_cap_t         hold_cap_q;
  logic [CntW-1:0]  clr_cnt_q;
  logic             err_q;

  logic             req_d, we_d, busy_d, done_d;
  logic             tmo_fire;
  logic             start_fire, tmo_hit, snoop_hit, snoop_window, conflict_now;
  logic             counted_state;
  logic [AddrW-1:0] start_al, end_al;
  logic [AddrW:0]   next_addr;
  reg_cap_t         ld_cap_untagged;

  // Shared decode used by the FSM and datapath
  always_comb begin
    start_fire      = (state_q == IDLE) && tbre_start_i;
    start_al        = tbre_start_addr_i & SlotMask;
    end_al          = tbre_end_addr_i & SlotMask;
    tmo_hit         = (tmo_cnt_q == TmoW'(LdStTimeout - 1));
    snoop_hit       = snoop_lsu_req_done_i && snoop_lsu_we_i &&
                      (((snoop_lsu_addr_i ^ cur_addr_q) & SlotMask) == '0);
    snoop_window    = ((state_q == LD_REQ) && lsu_tbre_req_done_i) ||
                      (state_q == LD_WAIT) || (state_q == VK_WAIT);
    conflict_now    = conflict_q || (snoop_window && snoop_hit);
    next_addr       = {1'b0, cur_addr_q} + (AddrW + 1)'(8);
    counted_state   = (state_q == LD_REQ) || (state_q == LD_WAIT) ||
                      (state_q == VK_WAIT) || (state_q == ST_REQ) ||
                      (state_q == ST_WAIT);
    ld_cap_untagged       = rf_wcap_lsu_i;
    ld_cap_untagged.valid = 1'b0;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    tmo_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (tbre_start_i) state_d = (start_al >= end_al) ? FIN : LD_REQ;
      end
      LD_REQ: begin
        if (lsu_tbre_req_done_i) state_d = LD_WAIT;
        else if (tmo_hit) begin state_d = FIN; tmo_fire = 1'b1; end
      end
      LD_WAIT: begin
        if (lsu_tbre_resp_valid_i) state_d = VK_WAIT;
        else if (tmo_hit) begin state_d = FIN; tmo_fire = 1'b1; end
      end
      VK_WAIT: begin
        if (tbre_trvk_en_i) state_d = (tbre_trvk_clrtag_i && !conflict_now) ? ST_REQ : NEXT;
        else if (tmo_hit) begin state_d = FIN; tmo_fire = 1'b1; end
      end
      ST_REQ: begin
        if (lsu_tbre_req_done_i) state_d = ST_WAIT;
        else if (tmo_hit) begin state_d = FIN; tmo_fire = 1'b1; end
      end
      ST_WAIT: begin
        if (lsu_tbre_resp_valid_i) state_d = NEXT;
        else if (tmo_hit) begin state_d = FIN; tmo_fire = 1'b1; end
      end
      NEXT: begin
        if (stop_pend_q || tbre_stop_i || next_addr[AddrW] ||
            (next_addr[AddrW-1:0] >= end_q)) state_d = FIN;
        else state_d = LD_REQ;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode, registered below so outputs change only on clock edges
  always_comb begin
    req_d  = 1'b0;
    we_d   = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    req_d  = (state_d == LD_REQ) || (state_d == ST_REQ);
    we_d   = (state_d == ST_REQ);
    busy_d = (state_d != IDLE);
    done_d = (state_q == FIN);
  end

  // Registered control outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tbre_lsu_req_o    <= 1'b0;
      tbre_lsu_we_o     <= 1'b0;
      tbre_lsu_is_cap_o <= 1'b0;
      tbre_busy_o       <= 1'b0;
      tbre_done_o       <= 1'b0;
    end else begin
      tbre_lsu_req_o    <= req_d;
      tbre_lsu_we_o     <= we_d;
      tbre_lsu_is_cap_o <= req_d;
      tbre_busy_o       <= busy_d;
      tbre_done_o       <= done_d;
    end
  end

  // Sweep pointer, range end, timeout counter and per-slot flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_addr_q  <= '0;
      end_q       <= '0;
      tmo_cnt_q   <= '0;
      conflict_q  <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      if (start_fire) begin
        cur_addr_q <= start_al;
        end_q      <= end_al;
      end else if (state_q == NEXT) begin
        cur_addr_q <= next_addr[AddrW-1:0];
      end

      if (state_d != state_q)  tmo_cnt_q <= '0;
      else if (counted_state)  tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
      else                     tmo_cnt_q <= '0;

      if ((state_d == LD_REQ) && (state_q != LD_REQ)) conflict_q <= 1'b0;
      else if (snoop_window && snoop_hit)             conflict_q <= 1'b1;

      if (state_q == IDLE)  stop_pend_q <= 1'b0;
      else if (tbre_stop_i) stop_pend_q <= 1'b1;
    end
  end

  // Loaded data hold, revoked count and sticky timeout flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_data_q <= '0;
      hold_cap_q  <= NULL_REG_CAP;
      clr_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      if ((state_q == LD_WAIT) && lsu_tbre_resp_valid_i) begin
        hold_data_q <= rf_wdata_lsu_i;
        hold_cap_q  <= ld_cap_untagged;
      end

      if (start_fire) clr_cnt_q <= '0;
      else if ((state_q == ST_WAIT) && lsu_tbre_resp_valid_i && !lsu_tbre_resp_err_i)
        clr_cnt_q <= clr_cnt_q + CntW'(1);

      if (start_fire)    err_q <= 1'b0;
      else if (tmo_fire) err_q <= 1'b1;
    end
  end

  assign tbre_lsu_addr_o  = cur_addr_q;
  assign tbre_lsu_wdata_o = hold_data_q;
  assign tbre_lsu_wcap_o  = hold_cap_q;
  assign tbre_clr_cnt_o   = clr_cnt_q;
  assign tbre_err_o       = err_q;

endmodule

// File: tb/tb_cheri_tbre_sweep.sv
// Bench for the revocation sweep: a reactive LSU/revoker model plus a
// slot-list reference model derived from the sweep rules.

module tb_cheri_tbre_sweep;
  import cheri_tbre_sweep_pkg::*;

  localparam int unsigned Tmo       = 16;
  localparam int          MaxSlots  = 16;
  localparam int unsigned RegCapW   = $bits(reg_cap_t);
  localparam int          WaitBound = 2000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        tbre_start_i = 1'b0;
  logic        tbre_stop_i = 1'b0;
  logic [31:0] tbre_start_addr_i = '0;
  logic [31:0] tbre_end_addr_i = '0;
  logic        tbre_busy_o, tbre_done_o, tbre_err_o;
  logic [31:0] tbre_clr_cnt_o;
  logic        tbre_lsu_req_o, tbre_lsu_we_o, tbre_lsu_is_cap_o;
  logic [31:0] tbre_lsu_addr_o, tbre_lsu_wdata_o;
  reg_cap_t    tbre_lsu_wcap_o;
  logic        lsu_tbre_req_done_i = 1'b0;
  logic        lsu_tbre_resp_valid_i = 1'b0;
  logic        lsu_tbre_resp_err_i = 1'b0;
  logic [31:0] rf_wdata_lsu_i = '0;
  reg_cap_t    rf_wcap_lsu_i = NULL_REG_CAP;
  logic        tbre_trvk_en_i = 1'b0;
  logic        tbre_trvk_clrtag_i = 1'b0;
  logic        snoop_lsu_req_done_i = 1'b0;
  logic        snoop_lsu_we_i = 1'b0;
  logic [31:0] snoop_lsu_addr_i = '0;

  always #5 clk_i = ~clk_i;

  cheri_tbre_sweep #(.LdStTimeout(Tmo)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .tbre_start_i(tbre_start_i), .tbre_stop_i(tbre_stop_i),
    .tbre_start_addr_i(tbre_start_addr_i), .tbre_end_addr_i(tbre_end_addr_i),
    .tbre_busy_o(tbre_busy_o), .tbre_done_o(tbre_done_o), .tbre_err_o(tbre_err_o),
    .tbre_clr_cnt_o(tbre_clr_cnt_o),
    .tbre_lsu_req_o(tbre_lsu_req_o), .tbre_lsu_we_o(tbre_lsu_we_o),
    .tbre_lsu_is_cap_o(tbre_lsu_is_cap_o), .tbre_lsu_addr_o(tbre_lsu_addr_o),
    .tbre_lsu_wdata_o(tbre_lsu_wdata_o), .tbre_lsu_wcap_o(tbre_lsu_wcap_o),
    .lsu_tbre_req_done_i(lsu_tbre_req_done_i), .lsu_tbre_resp_valid_i(lsu_tbre_resp_valid_i),
    .lsu_tbre_resp_err_i(lsu_tbre_resp_err_i), .rf_wdata_lsu_i(rf_wdata_lsu_i),
    .rf_wcap_lsu_i(rf_wcap_lsu_i), .tbre_trvk_en_i(tbre_trvk_en_i),
    .tbre_trvk_clrtag_i(tbre_trvk_clrtag_i), .snoop_lsu_req_done_i(snoop_lsu_req_done_i),
    .snoop_lsu_we_i(snoop_lsu_we_i), .snoop_lsu_addr_i(snoop_lsu_addr_i)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    reg_cap_t    wcap;
  } txn_t;

  txn_t got_q[$];
  txn_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Per-slot plan: revoker verdict, load/store errors, CPU snoop kind
  // (0 none, 1 store same slot, 2 store next slot, 3 load same slot)
  logic [31:0] plan_base = '0;
  bit          revoke_p[MaxSlots];
  bit          ld_err_p[MaxSlots];
  bit          st_err_p[MaxSlots];
  int          snoop_p[MaxSlots];
  logic [2:0]  snoop_off_p[MaxSlots];
  logic [31:0] data_p[MaxSlots];
  reg_cap_t    cap_p[MaxSlots];
  int          stop_slot = -1;
  bit          withhold_ld = 1'b0;
  bit          withhold_st = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int slot_idx(input logic [31:0] a);
    logic [31:0] d;
    d = (a - plan_base) >> 3;
    return (d < 32'(MaxSlots)) ? int'(d) : 0;
  endfunction

  // LSU + revocation-stage responder
  initial begin : responder
    int          gnt_wait, rsp_wait, vk_wait, idx;
    bit          pend_rsp, pend_vk, cur_we, prev_req, prev_gnt, prev_we, gnt_now;
    logic [31:0] cur_a, prev_addr, prev_wdata;
    txn_t        t;
    gnt_wait = 0; rsp_wait = 0; vk_wait = 0;
    pend_rsp = 0; pend_vk = 0; cur_we = 0; prev_req = 0; prev_gnt = 0; prev_we = 0;
    cur_a = '0; prev_addr = '0; prev_wdata = '0;
    forever begin
      @(negedge clk_i);
      lsu_tbre_req_done_i = 0; lsu_tbre_resp_valid_i = 0; lsu_tbre_resp_err_i = 0;
      tbre_trvk_en_i = 0; tbre_trvk_clrtag_i = 0; tbre_stop_i = 0;
      snoop_lsu_req_done_i = 0; snoop_lsu_we_i = 0; snoop_lsu_addr_i = '0;
      rf_wdata_lsu_i = '0; rf_wcap_lsu_i = NULL_REG_CAP;
      if (!rst_ni) begin
        pend_rsp = 0; pend_vk = 0; prev_req = 0; prev_gnt = 0; gnt_wait = 0;
        continue;
      end
      if (prev_gnt) check("req_drop_after_grant", 64'(tbre_lsu_req_o), 64'd0);
      else if (prev_req && tbre_lsu_req_o) begin
        check("req_addr_stable", 64'(tbre_lsu_addr_o), 64'(prev_addr));
        check("req_we_stable", 64'(tbre_lsu_we_o), 64'(prev_we));
        if (tbre_lsu_we_o) check("req_wdata_stable", 64'(tbre_lsu_wdata_o), 64'(prev_wdata));
      end
      gnt_now = 0;
      idx = slot_idx(cur_a);
      if (pend_rsp) begin
        if (rsp_wait == 0) begin
          pend_rsp = 0;
          lsu_tbre_resp_valid_i = 1;
          if (cur_we) lsu_tbre_resp_err_i = st_err_p[idx];
          else begin
            lsu_tbre_resp_err_i = ld_err_p[idx];
            rf_wdata_lsu_i = data_p[idx];
            rf_wcap_lsu_i = cap_p[idx];
            pend_vk = 1;
            vk_wait = 3;
            if (snoop_p[idx] != 0) begin
              snoop_lsu_req_done_i = 1;
              snoop_lsu_we_i = (snoop_p[idx] != 3);
              snoop_lsu_addr_i = cur_a + ((snoop_p[idx] == 2) ? 32'd8 : 32'd0) + 32'(snoop_off_p[idx]);
            end
          end
        end else rsp_wait--;
      end else if (pend_vk) begin
        vk_wait--;
        if (vk_wait == 0) begin
          tbre_trvk_en_i = 1;
          tbre_trvk_clrtag_i = revoke_p[idx] && !ld_err_p[idx];
          pend_vk = 0;
        end
      end else if (tbre_lsu_req_o && !prev_gnt) begin
        if ((!tbre_lsu_we_o && withhold_ld) || (tbre_lsu_we_o && withhold_st)) begin
        end else if (gnt_wait != 0) gnt_wait--;
        else begin
          lsu_tbre_req_done_i = 1;
          gnt_now = 1;
          check("is_cap_at_grant", 64'(tbre_lsu_is_cap_o), 64'd1);
          t.we = tbre_lsu_we_o; t.addr = tbre_lsu_addr_o;
          t.wdata = tbre_lsu_wdata_o; t.wcap = tbre_lsu_wcap_o;
          got_q.push_back(t);
          cur_we = tbre_lsu_we_o; cur_a = tbre_lsu_addr_o;
          pend_rsp = 1;
          rsp_wait = int'($urandom_range(0, 2));
          gnt_wait = int'($urandom_range(0, 2));
          if (!tbre_lsu_we_o && (slot_idx(tbre_lsu_addr_o) == stop_slot)) tbre_stop_i = 1;
        end
      end
      prev_req = tbre_lsu_req_o; prev_addr = tbre_lsu_addr_o;
      prev_we = tbre_lsu_we_o; prev_wdata = tbre_lsu_wdata_o; prev_gnt = gnt_now;
    end
  end

  task automatic clear_plan();
    reg_cap_t c;
    for (int i = 0; i < MaxSlots; i++) begin
      revoke_p[i] = 0; ld_err_p[i] = 0; st_err_p[i] = 0; snoop_p[i] = 0; snoop_off_p[i] = '0;
      data_p[i] = $urandom;
      c = reg_cap_t'(RegCapW'($urandom));
      c.valid = 1'b1;
      cap_p[i] = c;
    end
    stop_slot = -1; withhold_ld = 0; withhold_st = 0;
  endtask

  // Reference: walk slots [start, end) in 8-byte steps, truncate at the stop slot
  task automatic build_expected(input logic [31:0] s, input logic [31:0] e, input bit tmo,
                                output int exp_clr);
    longint a, ee;
    int     idx;
    txn_t   t;
    reg_cap_t c;
    exp_q.delete();
    exp_clr = 0;
    if (tmo) return;
    a = longint'(s & 32'hFFFF_FFF8);
    ee = longint'(e & 32'hFFFF_FFF8);
    idx = 0;
    while (a < ee) begin
      t.we = 0; t.addr = 32'(a); t.wdata = '0; t.wcap = NULL_REG_CAP;
      exp_q.push_back(t);
      if (revoke_p[idx] && !ld_err_p[idx] && snoop_p[idx] != 1) begin
        c = cap_p[idx]; c.valid = 1'b0;
        t.we = 1; t.wdata = data_p[idx]; t.wcap = c;
        exp_q.push_back(t);
        if (!st_err_p[idx]) exp_clr++;
      end
      if (idx == stop_slot) break;
      a += 8;
      idx++;
    end
  endtask

  task automatic run_sweep(input string tag, input logic [31:0] s, input logic [31:0] e,
                           input bit tmo);
    int exp_clr, cyc, req_cycles, n;
    plan_base = s & 32'hFFFF_FFF8;
    build_expected(s, e, tmo, exp_clr);
    got_q.delete();
    @(negedge clk_i);
    tbre_start_i = 1; tbre_start_addr_i = s; tbre_end_addr_i = e;
    @(negedge clk_i);
    tbre_start_i = 0;
    check({tag, "_busy_after_start"}, 64'(tbre_busy_o), 64'd1);
    check({tag, "_err_cleared"}, 64'(tbre_err_o), 64'd0);
    check({tag, "_cnt_cleared"}, 64'(tbre_clr_cnt_o), 64'd0);
    cyc = 0; req_cycles = 0;
    while (1) begin
      if (tbre_lsu_req_o) req_cycles++;
      if (tbre_done_o || cyc >= WaitBound) break;
      @(negedge clk_i);
      cyc++;
    end
    check({tag, "_done_seen"}, 64'(tbre_done_o), 64'd1);
    check({tag, "_busy_at_done"}, 64'(tbre_busy_o), 64'd0);
    check({tag, "_err"}, 64'(tbre_err_o), 64'(tmo));
    check({tag, "_clr_cnt"}, 64'(tbre_clr_cnt_o), 64'(exp_clr));
    if (tmo) check({tag, "_req_cycles"}, 64'(req_cycles), 64'(Tmo));
    @(negedge clk_i);
    check({tag, "_done_one_cycle"}, 64'(tbre_done_o), 64'd0);
    check({tag, "_err_sticky"}, 64'(tbre_err_o), 64'(tmo));
    check({tag, "_txn_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_txn%0d_we", tag, i), 64'(got_q[i].we), 64'(exp_q[i].we));
      check($sformatf("%s_txn%0d_addr", tag, i), 64'(got_q[i].addr), 64'(exp_q[i].addr));
      if (exp_q[i].we) begin
        check($sformatf("%s_txn%0d_wdata", tag, i), 64'(got_q[i].wdata), 64'(exp_q[i].wdata));
        check($sformatf("%s_txn%0d_wcap", tag, i), 64'(got_q[i].wcap), 64'(exp_q[i].wcap));
      end
    end
  endtask

  initial begin : main
    bit          found, saw;
    int          n;
    logic [31:0] base;

    clear_plan();
    repeat (2) @(negedge clk_i);
    check("rst_busy", 64'(tbre_busy_o), 64'd0);
    check("rst_done", 64'(tbre_done_o), 64'd0);
    check("rst_err", 64'(tbre_err_o), 64'd0);
    check("rst_req", 64'(tbre_lsu_req_o), 64'd0);
    check("rst_clr_cnt", 64'(tbre_clr_cnt_o), 64'd0);
    check("rst_wcap", 64'(tbre_lsu_wcap_o), 64'(NULL_REG_CAP));
    rst_ni = 1;

    // Four slots, nothing revoked
    clear_plan();
    run_sweep("t1", 32'h2001_0000, 32'h2001_0020, 0);

    // Slot 0x8 revoked
    clear_plan();
    revoke_p[1] = 1;
    run_sweep("t2", 32'h2001_0000, 32'h2001_0020, 0);

    // Slot 0x10 revoked but the CPU stores to 0x14 before the verdict
    clear_plan();
    revoke_p[2] = 1; snoop_p[2] = 1; snoop_off_p[2] = 3'd4;
    run_sweep("t3", 32'h2001_0000, 32'h2001_0020, 0);

    // Empty range: one busy cycle, done the cycle after
    clear_plan();
    got_q.delete();
    @(negedge clk_i);
    tbre_start_i = 1; tbre_start_addr_i = 32'h2001_0040; tbre_end_addr_i = 32'h2001_0040;
    @(negedge clk_i);
    tbre_start_i = 0;
    check("t4_c1_busy", 64'(tbre_busy_o), 64'd1);
    check("t4_c1_done", 64'(tbre_done_o), 64'd0);
    check("t4_c1_req", 64'(tbre_lsu_req_o), 64'd0);
    @(negedge clk_i);
    check("t4_c2_busy", 64'(tbre_busy_o), 64'd0);
    check("t4_c2_done", 64'(tbre_done_o), 64'd1);
    @(negedge clk_i);
    check("t4_c3_done", 64'(tbre_done_o), 64'd0);
    check("t4_no_txn", 64'(got_q.size()), 64'd0);

    // Grant withheld: timeout, then a fresh start clears err
    clear_plan();
    withhold_ld = 1;
    run_sweep("t5", 32'h2001_0000, 32'h2001_0020, 1);
    clear_plan();
    revoke_p[0] = 1;
    run_sweep("t5b", 32'h2001_0000, 32'h2001_0020, 0);

    // Stop during slot 1, which is revoked
    clear_plan();
    revoke_p[1] = 1; stop_slot = 1;
    run_sweep("t6", 32'h2001_0000, 32'h2001_0020, 0);

    // Asynchronous reset while a store request is pending
    clear_plan();
    plan_base = 32'h2001_0000;
    revoke_p[0] = 1; withhold_st = 1;
    got_q.delete();
    @(negedge clk_i);
    tbre_start_i = 1; tbre_start_addr_i = 32'h2001_0000; tbre_end_addr_i = 32'h2001_0020;
    @(negedge clk_i);
    tbre_start_i = 0;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (tbre_lsu_req_o && tbre_lsu_we_o) found = 1;
      else @(negedge clk_i);
    end
    check("t6r_store_req_seen", 64'(found), 64'd1);
    #2 rst_ni = 0;
    #1;
    check("t6r_req_async", 64'(tbre_lsu_req_o), 64'd0);
    check("t6r_busy_async", 64'(tbre_busy_o), 64'd0);
    check("t6r_cnt_async", 64'(tbre_clr_cnt_o), 64'd0);
    repeat (2) @(negedge clk_i);
    withhold_st = 0;
    rst_ni = 1;
    saw = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (tbre_lsu_req_o || tbre_busy_o) saw = 1;
    end
    check("t6r_quiet_after_reset", 64'(saw), 64'd0);

    // Randomised sweeps
    for (int r = 0; r < 8; r++) begin
      clear_plan();
      n = int'($urandom_range(1, 12));
      base = 32'h3000_0000 + (32'($urandom_range(0, 4095)) << 7);
      for (int i = 0; i < n; i++) begin
        revoke_p[i] = 1'($urandom_range(0, 1));
        ld_err_p[i] = ($urandom_range(0, 7) == 0);
        st_err_p[i] = ($urandom_range(0, 5) == 0);
        snoop_p[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
        snoop_off_p[i] = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 2) == 0) stop_slot = int'($urandom_range(0, n - 1));
      run_sweep($sformatf("rnd%0d", r), base | 32'($urandom_range(0, 7)),
                (base + 32'(n * 8)) | 32'($urandom_range(0, 7)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cheri_tbre_sweep.md
Name: cheri_tbre_sweep

Overview:
- Background revocation sweep engine: walks a software-programmed memory range one 8-byte capability at a time.
- For each slot it issues a capability load on the TBRE LSU port.
- The revocation stage downstream of the LSU (3-stage tsmap lookup) classifies the loaded cap; this block consumes its verdict (tbre_trvk_en_i/tbre_trvk_clrtag_i).
- When the verdict is "revoked", it writes the same capability back with the tag cleared, unless the CPU has stored to that slot in the meantime.

Parameters:
- LdStTimeout, 16'hFFFF, max cycles waiting for grant or response before the sweep aborts with an error.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- tbre_start_i  input  1  start pulse (ignored while busy)
- tbre_stop_i  input  1  stop request, honoured at the next slot boundary
- tbre_start_addr_i  input  32  first slot address (bits[2:0] ignored)
- tbre_end_addr_i  input  32  exclusive end address (bits[2:0] ignored)
- tbre_busy_o  output  1  sweep in progress
- tbre_done_o  output  1  one-cycle pulse on completion, stop or error
- tbre_err_o  output  1  sticky timeout flag, cleared by the next start
- tbre_clr_cnt_o  output  32  caps revoked in the current or last sweep
- tbre_lsu_req_o  output  1  LSU request
- tbre_lsu_we_o  output  1  1 = store, 0 = load
- tbre_lsu_is_cap_o  output  1  always 1 when req is high
- tbre_lsu_addr_o  output  32  access address, bits[2:0] = 0
- tbre_lsu_wdata_o  output  32  store address word
- tbre_lsu_wcap_o  output  reg_cap_t  store capability metadata, valid = 0
- lsu_tbre_req_done_i  input  1  grant, request accepted
- lsu_tbre_resp_valid_i  input  1  response for the TBRE access
- lsu_tbre_resp_err_i  input  1  response error
- rf_wdata_lsu_i  input  32  loaded address word
- rf_wcap_lsu_i  input  reg_cap_t  loaded capability
- tbre_trvk_en_i  input  1  revocation verdict valid
- tbre_trvk_clrtag_i  input  1  verdict: clear tag
- snoop_lsu_req_done_i  input  1  CPU LSU request accepted
- snoop_lsu_we_i  input  1  CPU request is a store
- snoop_lsu_addr_i  input  32  CPU request address

Behaviour:
Reset values:
- All outputs 0; tbre_lsu_wcap_o = NULL_REG_CAP.
- State IDLE.
- Reset mid-sweep returns to IDLE with no further requests; an in-flight response is ignored because it arrives in IDLE.

Start:
- In IDLE, tbre_start_i latches cur_addr = {start[31:3],3'b0} and end_q = {end[31:3],3'b0}.
- Clears clr_cnt and err; busy = 1 next cycle.
- If cur_addr >= end_q (unsigned): go to FIN; no access is issued.

States:
- LD_REQ: req=1, we=0, addr=cur_addr. Clear the conflict flag on entry. On grant -> LD_WAIT.
- LD_WAIT: on lsu_tbre_resp_valid_i, capture rf_wdata_lsu_i/rf_wcap_lsu_i into hold registers (even on error) -> VK_WAIT.
- VK_WAIT:
  - Wait for tbre_trvk_en_i, nominally 3 cycles after the response; the verdict also arrives for error loads, with clrtag=0.
  - clrtag=1 and no conflict -> ST_REQ.
  - Otherwise -> NEXT.
- ST_REQ: req=1, we=1, addr=cur_addr, wdata=held data, wcap=held cap with valid forced to 0. On grant -> ST_WAIT.
- ST_WAIT: on resp_valid, clr_cnt += 1 if resp_err=0 (wraps at 2^32) -> NEXT.
- NEXT:
  - cur_addr += 8.
  - If stop is pending, or cur_addr+8 >= end_q, or cur_addr+8 wraps past 0 -> FIN.
  - Otherwise -> LD_REQ.
- FIN: done=1 for one cycle, busy=0 -> IDLE.

Request handshake:
- req, we, addr, wdata and wcap are held stable from assertion until the grant cycle inclusive.
- req drops the cycle after the grant.

Conflict snoop:
- From LD_REQ grant until leaving VK_WAIT, any snoop_lsu_req_done_i with snoop_lsu_we_i=1 and snoop_lsu_addr_i[31:3] == cur_addr[31:3] sets the conflict flag.
- A snoop in the same cycle as the verdict also counts.
- With the conflict flag set, the write-back is skipped.

Stop:
- tbre_stop_i in any busy state sets stop_pending, which is sampled in NEXT.
- stop in the same cycle as start: start wins; stop is ignored.

Timeout:
- A counter resets on each state entry and counts in LD_REQ, LD_WAIT, VK_WAIT, ST_REQ and ST_WAIT.
- Reaching LdStTimeout -> err=1 -> FIN.

Only one access is outstanding at a time; no pipelining.

Test Plan:
1. start=0x2001_0000, end=0x2001_0020, all verdicts clrtag=0 -> 4 loads at addresses +0, +8, +0x10, +0x18; no stores; done pulse; clr_cnt=0.
2. Same range, verdict clrtag=1 on slot 0x2001_0008 -> exactly one store at 0x2001_0008 with wdata equal to the loaded word and wcap.valid=0; clr_cnt=1.
3. clrtag=1 on slot 0x2001_0010, plus a CPU store snoop to 0x2001_0014 between load grant and verdict -> no store; clr_cnt=0.
4. start=end=0x2001_0040 -> no requests; done 2 cycles after start; busy high for exactly 1 cycle.
5. Grant withheld, LdStTimeout=16 -> req held with a stable address; err=1 and done pulse after 16 cycles; next start clears err.
6. stop asserted during slot 1 of 4 -> slot 1 completes (including its write-back if revoked), no slot-2 load, done pulse; async reset mid-ST_REQ -> req=0 immediately, busy=0.
